// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring DIV/DIVU sequencer; result_o = {remainder, quotient}.
// Optional macro DIV_EARLY_EXIT_EN: finish at once when |dividend| < |divisor|.
module div_seq #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stall_o,
  output logic                  busy_o
);

  localparam int unsigned CntW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {StIdle, StDivZero, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     dvd_q, dvd_d;
  logic [DATA_W-1:0]     dsr_q, dsr_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic [2*DATA_W-1:0]   result_q, result_d;

  logic                  neg1, neg2;
  logic [DATA_W-1:0]     mag1, mag2;
  logic [DATA_W:0]       shifted, diff;
  logic                  qbit;
  logic [DATA_W-1:0]     rem_step, dvd_step, q_fix, r_fix;

  assign neg1 = signed_i & opdata1_i[DATA_W-1];
  assign neg2 = signed_i & opdata2_i[DATA_W-1];
  assign mag1 = neg1 ? -opdata1_i : opdata1_i;
  assign mag2 = neg2 ? -opdata2_i : opdata2_i;

  // No borrow out of the (DATA_W+1)-bit subtraction means shifted >= divisor.
  assign shifted  = {rem_q, dvd_q[DATA_W-1]};
  assign diff     = shifted - {1'b0, dsr_q};
  assign qbit     = ~diff[DATA_W];
  assign rem_step = qbit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign dvd_step = {dvd_q[DATA_W-2:0], qbit};
  assign q_fix    = q_neg_q ? -dvd_step : dvd_step;
  assign r_fix    = r_neg_q ? -rem_step : rem_step;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          rem_d   = '0;
          dvd_d   = mag1;
          dsr_d   = mag2;
          q_neg_d = neg1 ^ neg2;
          r_neg_d = neg1;
          cnt_d   = '0;
          if (mag2 == '0) begin
            state_d = StDivZero;
`ifdef DIV_EARLY_EXIT_EN
          end else if (mag1 < mag2) begin
            state_d  = StDone;
            result_d = {opdata1_i, {DATA_W{1'b0}}};
`endif
          end else begin
            state_d = StRun;
          end
        end
      end
      StDivZero: begin
        // Divide by zero is unpredictable architecturally; report zero.
        state_d  = annul_i ? StIdle : StDone;
        result_d = '0;
      end
      StRun: begin
        if (annul_i) begin
          state_d  = StIdle;
          result_d = '0;
        end else begin
          rem_d = rem_step;
          dvd_d = dvd_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            state_d  = StDone;
            result_d = {r_fix, q_fix};
          end
        end
      end
      StDone: begin
        // Hold the result while EX keeps start_i high for an unrelated stall.
        if (annul_i || !start_i) begin
          state_d  = StIdle;
          result_d = '0;
        end
      end
      default: begin
        state_d  = StIdle;
        result_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dsr_q    <= dsr_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == StDone);
  assign busy_o   = (state_q != StIdle);
  assign stall_o  = start_i & ~ready_o;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed scenarios plus random ops against an arithmetic model.
module tb_div_seq;
  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst, start_i, annul_i, signed_i;
  logic [W-1:0]  op1, op2;
  logic [2*W-1:0] result_o;
  logic          ready_o, stall_o, busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_seq #(.DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .opdata1_i (op1),
    .opdata2_i (op2),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .stall_o   (stall_o),
    .busy_o    (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint ext(input logic [W-1:0] v, input logic sgn);
    if (sgn) return longint'(signed'(v));
    return longint'(v);
  endfunction

  // Truncating division in 64-bit arithmetic; the remainder takes the dividend's sign.
  function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sgn);
    longint sa, sb, q, r;
    if (b == '0) return 64'd0;
    sa = ext(a, sgn);
    sb = ext(b, sgn);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sgn);
    longint sa, sb;
    sa = ext(a, sgn);
    sb = ext(b, sgn);
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
    if (b == '0) return 2;
`ifdef DIV_EARLY_EXIT_EN
    if (sa < sb) return 1;
`endif
    return W + 1;
  endfunction

  // Issue one op at the current cycle (T), hold start until ready, then drop it.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input int hold);
    logic [63:0] exp;
    int          exp_lat, lat;
    bit          stall_bad;
    exp     = ref_div(a, b, sgn);
    exp_lat = ref_lat(a, b, sgn);
    start_i = 1'b1;
    annul_i = 1'b0;
    signed_i = sgn;
    op1 = a;
    op2 = b;
    #1;
    chk({tag, "_stall_T"}, 64'(stall_o), 64'd1);
    lat = 0;
    stall_bad = 1'b0;
    while (ready_o !== 1'b1 && lat < 200) begin
      tick();
      lat++;
      // Operands are latched at acceptance; later changes must not matter.
      op1 = $urandom;
      op2 = $urandom;
      signed_i = $urandom_range(0, 1);
      if (ready_o !== 1'b1 && stall_o !== 1'b1) stall_bad = 1'b1;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_result"}, result_o, exp);
    chk({tag, "_stall_ready"}, 64'(stall_o), 64'd0);
    chk({tag, "_stall_window"}, 64'(stall_bad), 64'd0);
    if (hold > 0) begin
      repeat (hold) tick();
      chk({tag, "_held_ready"}, 64'(ready_o), 64'd1);
      chk({tag, "_held_result"}, result_o, exp);
    end
    start_i = 1'b0;
    tick();
    chk({tag, "_idle_ready"}, 64'(ready_o), 64'd0);
    chk({tag, "_idle_result"}, result_o, 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    bit          seen;
    logic [W-1:0] a, b;
    logic        s;
    int          mode;

    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_i = 1'b0;
    op1 = '0;
    op2 = '0;
    tick();
    tick();
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_stall", 64'(stall_o), 64'd0);
    rst = 1'b0;
    tick();

    run_op("divu_100_7", 32'd100, 32'd7, 1'b0, 2);
    run_op("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_op("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_op("divu_5_0", 32'd5, 32'd0, 1'b0, 1);
    run_op("after_zero", 32'd50, 32'd5, 1'b0, 0);

    // Start with annul in IDLE is not accepted.
    start_i = 1'b1;
    annul_i = 1'b1;
    op1 = 32'd10;
    op2 = 32'd2;
    tick();
    chk("annul_idle_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();

    // Annul at RUN cnt=10.
    start_i = 1'b1;
    op1 = 32'd1000;
    op2 = 32'd3;
    signed_i = 1'b0;
    tick();
    chk("annul_run_busy", 64'(busy_o), 64'd1);
    repeat (10) tick();
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    annul_i = 1'b0;
    chk("annul_busy", 64'(busy_o), 64'd0);
    chk("annul_result", result_o, 64'd0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (ready_o !== 1'b0) seen = 1'b1;
    end
    chk("annul_no_ready", 64'(seen), 64'd0);
    run_op("divu_9_3", 32'd9, 32'd3, 1'b0, 0);

    // Reset mid-RUN.
    start_i = 1'b1;
    op1 = 32'd12345;
    op2 = 32'd7;
    tick();
    repeat (5) tick();
    rst = 1'b1;
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_result", result_o, 64'd0);
    run_op("div_minneg", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op("divu_3_10", 32'd3, 32'd10, 1'b0, 0);
    run_op("div_m3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, 0);

    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 3);
      a = $urandom;
      s = 1'(($urandom_range(0, 1)));
      case (mode)
        0: b = '0;
        1: begin
          b = 32'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 1) a = 32'($urandom_range(0, 20));
        end
        2: b = $urandom;
        default: b = a >> $urandom_range(0, 31);
      endcase
      run_op("random", a, b, s, $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
